alu_share_ctrl: RTL

Sequencer and round-robin arbiter that shares one combinational ALU (5-bit opcode, two signed 32-bit sources, 32-bit result) between two requesters, for example the execute path and a branch/compare unit. It owns the ALU operand and opcode inputs and runs each operation as a registered multi-cycle transaction. It returns the result, a condition flag and an error bit to the requester that issued the operation, over valid/ready handshakes.

---
 rtl/alu_share_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters. Each operation runs as a
// three-phase transaction: accept in IDLE, one EXEC cycle, then RESP until the owner takes the result.
module alu_share_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [OP_WIDTH-1:0]   req0_op,
  input  logic [DATA_WIDTH-1:0] req0_src1,
  input  logic [DATA_WIDTH-1:0] req0_src2,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [OP_WIDTH-1:0]   req1_op,
  input  logic [DATA_WIDTH-1:0] req1_src1,
  input  logic [DATA_WIDTH-1:0] req1_src2,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [DATA_WIDTH-1:0] rsp0_data,
  output logic                  rsp0_flag,
  output logic                  rsp0_err,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp1_data,
  output logic                  rsp1_flag,
  output logic                  rsp1_err,
  output logic [DATA_WIDTH-1:0] alu_src1,
  output logic [DATA_WIDTH-1:0] alu_src2,
  output logic [OP_WIDTH-1:0]   alu_opcode,
  input  logic [DATA_WIDTH-1:0] alu_data_out,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  op_count
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_e;

  localparam logic [OP_WIDTH-1:0] OP_CMP_LO = OP_WIDTH'(9);
  localparam logic [OP_WIDTH-1:0] OP_CMP_HI = OP_WIDTH'(15);
  localparam logic [OP_WIDTH-1:0] OP_CMP_A  = OP_WIDTH'(17);
  localparam logic [OP_WIDTH-1:0] OP_CMP_B  = OP_WIDTH'(18);
  localparam logic [OP_WIDTH-1:0] OP_ILL_LO = OP_WIDTH'(19);

  state_e                  state_q, state_d;
  logic                    owner_q, owner_d;
  logic                    ptr_q, ptr_d;
  logic                    served_q, served_d;
  logic [OP_WIDTH-1:0]     op_q, op_d;
  logic [DATA_WIDTH-1:0]   src1_q, src1_d;
  logic [DATA_WIDTH-1:0]   src2_q, src2_d;
  logic [DATA_WIDTH-1:0]   res_q, res_d;
  logic                    flag_q, flag_d;
  logic                    err_q, err_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    grant;
  logic                    is_cmp;
  logic                    is_ill;
  logic                    owner_rsp_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      ptr_q    <= 1'b0;
      served_q <= 1'b0;
      op_q     <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      res_q    <= '0;
      flag_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      served_q <= served_d;
      op_q     <= op_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      res_q    <= res_d;
      flag_q   <= flag_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    served_d   = served_q;
    op_d       = op_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    res_d      = res_q;
    flag_d     = flag_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    // ptr_q is the last-served requester; until anything has been served req0 wins collisions.
    if (req0_valid && req1_valid) grant = served_q ? ~ptr_q : 1'b0;
    else                          grant = req1_valid;
    is_cmp = ((op_q >= OP_CMP_LO) && (op_q <= OP_CMP_HI)) ||
             (op_q == OP_CMP_A) || (op_q == OP_CMP_B);
    is_ill = (op_q >= OP_ILL_LO);
    owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;
    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          req0_ready = ~grant;
          req1_ready = grant;
          owner_d    = grant;
          op_d       = grant ? req1_op   : req0_op;
          src1_d     = grant ? req1_src1 : req0_src1;
          src2_d     = grant ? req1_src2 : req0_src2;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        res_d   = is_ill ? '0 : alu_data_out;
        flag_d  = ~is_ill & is_cmp & alu_data_out[0];
        err_d   = is_ill;
        state_d = RESP;
      end
      RESP: begin
        if (owner_rsp_ready) begin
          cnt_d    = cnt_q + CNT_WIDTH'(1);
          ptr_d    = owner_q;
          served_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp0_valid = (state_q == RESP) && !owner_q;
  assign rsp1_valid = (state_q == RESP) && owner_q;
  assign rsp0_data  = res_q;
  assign rsp1_data  = res_q;
  assign rsp0_flag  = flag_q;
  assign rsp1_flag  = flag_q;
  assign rsp0_err   = err_q;
  assign rsp1_err   = err_q;
  assign alu_opcode = op_q;
  assign alu_src1   = src1_q;
  assign alu_src2   = src2_q;
  assign busy       = (state_q != IDLE);
  assign op_count   = cnt_q;

endmodule
